// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 datapath (lb, sb, add, and, sll, ori, bne).
// Holds the state register, the retired-instruction counter and the sticky illegal flag.
// All datapath controls are decoded combinationally from the current state.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state;
  state_t next_state;
  logic   retire;

  assign state_dbg = state;

  // State register, retire counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (retire) retired <= retired + CNT_W'(1);
      if (next_state == S_TRAP) illegal <= 1'b1;
    end
  end

  // Next-state and control-output decode from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_state = state;
    retire     = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 3'b000;
    ResultSrc  = 2'b00;

    unique case (state)
      S_FETCH: begin
        // PC + 4 is computed in the ALU and loaded as the fetch completes.
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target (oldPC + imm) is precomputed into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADDR;
          OP_RTYPE:          next_state = S_EXEC_R;
          OP_ITYPE:          next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        ResultSrc  = 2'b01;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write request is held for every wait cycle of the memory.
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 3'b010;
        next_state = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 3'b011;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        // bne: compare with a subtract, load the precomputed target when not equal.
        ALUSrcA    = 2'b10;
        ALUOp      = 3'b001;
        PCWrite    = ~zero;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase

    // A reset cycle abandons any access in flight.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (4-bit counter build).
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]       ALUOp;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .illegal   (illegal),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LB  = 7'b0000011;
  localparam logic [6:0] OP_SB  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BNE = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Packed observation: {state, PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
  //                      ALUSrcA, ALUSrcB, ALUOp, ResultSrc}
  typedef logic [18:0] obs_t;

  function automatic obs_t pk(logic [3:0] st, logic pcw, logic irw, logic adr, logic mr,
                              logic mw, logic rw, logic [1:0] a, logic [1:0] b,
                              logic [2:0] op, logic [1:0] rs);
    return {st, pcw, irw, adr, mr, mw, rw, a, b, op, rs};
  endfunction

  // Expected outputs per state, written out by hand.
  function automatic obs_t e_fetch(logic rdy); return pk(4'd0, rdy, rdy, 0, 1, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10); endfunction
  function automatic obs_t e_dec();            return pk(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00); endfunction
  function automatic obs_t e_madr();           return pk(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00); endfunction
  function automatic obs_t e_mrd();            return pk(4'd3, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00); endfunction
  function automatic obs_t e_mwb();            return pk(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b01); endfunction
  function automatic obs_t e_mwr();            return pk(4'd5, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00); endfunction
  function automatic obs_t e_exr();            return pk(4'd6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b010, 2'b00); endfunction
  function automatic obs_t e_exi();            return pk(4'd7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b011, 2'b00); endfunction
  function automatic obs_t e_awb();            return pk(4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00); endfunction
  function automatic obs_t e_br(logic pcw);    return pk(4'd9, pcw, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b001, 2'b00); endfunction
  function automatic obs_t e_trap();           return pk(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00); endfunction

  typedef struct {
    logic [6:0]       op;
    logic             z;
    logic             rdy;
    obs_t             exp;
    logic [CNT_W-1:0] ret;
  } vec_t;

  vec_t vecs[24];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, compare mid-cycle, advance.
  // exp_ill < 0 skips the illegal-flag comparison.
  task automatic run_cycle(string name, logic [6:0] op, logic z, logic rdy,
                           obs_t exp, logic [CNT_W-1:0] exp_ret, int exp_ill);
    obs_t act;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    #3;
    act = {state_dbg, PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc};
    check({name, " outputs"}, 32'(act), 32'(exp));
    check({name, " retired"}, 32'(retired), 32'(exp_ret));
    if (exp_ill >= 0) check({name, " illegal"}, 32'(illegal), 32'(exp_ill));
    check({name, " rd/wr exclusive"}, 32'(MemRead & MemWrite), 32'd0);
    check({name, " regwr/memwr exclusive"}, 32'(RegWrite & MemWrite), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = OP_R;
    zero      = 1'b0;
    mem_ready = 1'b1;

    // Table: one record per cycle, continuing from FETCH with retired = 0.
    vecs[0]  = '{OP_R,   0, 0, e_fetch(0), 4'd0};
    vecs[1]  = '{OP_R,   0, 1, e_fetch(1), 4'd0};
    vecs[2]  = '{OP_R,   0, 1, e_dec(),    4'd0};
    vecs[3]  = '{OP_R,   0, 1, e_exr(),    4'd0};
    vecs[4]  = '{OP_R,   0, 1, e_awb(),    4'd0};
    vecs[5]  = '{OP_I,   0, 1, e_fetch(1), 4'd1};
    vecs[6]  = '{OP_I,   0, 1, e_dec(),    4'd1};
    vecs[7]  = '{OP_I,   0, 1, e_exi(),    4'd1};
    vecs[8]  = '{OP_I,   0, 1, e_awb(),    4'd1};
    vecs[9]  = '{OP_SB,  0, 1, e_fetch(1), 4'd2};
    vecs[10] = '{OP_SB,  0, 1, e_dec(),    4'd2};
    vecs[11] = '{OP_SB,  0, 1, e_madr(),   4'd2};
    vecs[12] = '{OP_SB,  0, 1, e_mwr(),    4'd2};
    vecs[13] = '{OP_BNE, 0, 1, e_fetch(1), 4'd3};
    vecs[14] = '{OP_BNE, 0, 1, e_dec(),    4'd3};
    vecs[15] = '{OP_BNE, 0, 1, e_br(1),    4'd3};
    vecs[16] = '{OP_BNE, 1, 1, e_fetch(1), 4'd4};
    vecs[17] = '{OP_BNE, 1, 1, e_dec(),    4'd4};
    vecs[18] = '{OP_BNE, 1, 1, e_br(0),    4'd4};
    vecs[19] = '{OP_LB,  0, 1, e_fetch(1), 4'd5};
    vecs[20] = '{OP_LB,  0, 1, e_dec(),    4'd5};
    vecs[21] = '{OP_LB,  0, 1, e_madr(),   4'd5};
    vecs[22] = '{OP_LB,  0, 1, e_mrd(),    4'd5};
    vecs[23] = '{OP_LB,  0, 1, e_mwb(),    4'd5};

    // Two reset cycles: FETCH encoding, strobes forced low.
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      run_cycle("reset", OP_R, 0, 1,
                pk(4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10), 4'd0, 0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++)
      run_cycle($sformatf("vec%0d", i), vecs[i].op, vecs[i].z, vecs[i].rdy,
                vecs[i].exp, vecs[i].ret, 0);

    // lb with three memory wait cycles: 8 cycles total.
    run_cycle("lbw fetch", OP_LB, 0, 1, e_fetch(1), 4'd6, 0);
    run_cycle("lbw dec",   OP_LB, 0, 1, e_dec(),    4'd6, 0);
    run_cycle("lbw madr",  OP_LB, 0, 1, e_madr(),   4'd6, 0);
    for (int i = 0; i < 3; i++)
      run_cycle("lbw wait", OP_LB, 0, 0, e_mrd(), 4'd6, 0);
    run_cycle("lbw rdy",   OP_LB, 0, 1, e_mrd(),    4'd6, 0);
    run_cycle("lbw wb",    OP_LB, 0, 1, e_mwb(),    4'd6, 0);

    // sb with two memory wait cycles: MemWrite held, retires on ready.
    run_cycle("sbw fetch", OP_SB, 0, 1, e_fetch(1), 4'd7, 0);
    run_cycle("sbw dec",   OP_SB, 0, 1, e_dec(),    4'd7, 0);
    run_cycle("sbw madr",  OP_SB, 0, 1, e_madr(),   4'd7, 0);
    for (int i = 0; i < 2; i++)
      run_cycle("sbw wait", OP_SB, 0, 0, e_mwr(), 4'd7, 0);
    run_cycle("sbw rdy",   OP_SB, 0, 1, e_mwr(),    4'd7, 0);

    // Illegal opcode: TRAP holds for 20 cycles with strobes low.
    run_cycle("trap fetch", OP_BAD, 0, 1, e_fetch(1), 4'd8, 0);
    run_cycle("trap dec",   OP_BAD, 0, 1, e_dec(),    4'd8, 0);
    for (int i = 0; i < 20; i++)
      run_cycle("trap hold", OP_BAD, 0, 1, e_trap(), 4'd8, (i == 0) ? -1 : 1);
    reset = 1'b1;
    run_cycle("trap reset", OP_BAD, 0, 1, e_trap(), 4'd8, 1);
    reset = 1'b0;
    run_cycle("trap cleared", OP_LB, 0, 0, e_fetch(0), 4'd0, 0);

    // Reset while MEMREAD waits: access dropped, back to FETCH, nothing retired.
    run_cycle("abort fetch", OP_LB, 0, 1, e_fetch(1), 4'd0, 0);
    run_cycle("abort dec",   OP_LB, 0, 1, e_dec(),    4'd0, 0);
    run_cycle("abort madr",  OP_LB, 0, 1, e_madr(),   4'd0, 0);
    run_cycle("abort wait",  OP_LB, 0, 0, e_mrd(),    4'd0, 0);
    reset = 1'b1;
    run_cycle("abort reset", OP_LB, 0, 0,
              pk(4'd3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00), 4'd0, 0);
    reset = 1'b0;
    run_cycle("abort after", OP_LB, 0, 0, e_fetch(0), 4'd0, 0);

    // Counter wrap: 15 bne to reach 2^CNT_W-1, one more wraps to 0.
    for (int i = 0; i < 15; i++) begin
      run_cycle("wrap fetch", OP_BNE, 1, 1, e_fetch(1), CNT_W'(i), 0);
      run_cycle("wrap dec",   OP_BNE, 1, 1, e_dec(),    CNT_W'(i), 0);
      run_cycle("wrap br",    OP_BNE, 1, 1, e_br(0),    CNT_W'(i), 0);
    end
    run_cycle("wrap full",  OP_BNE, 1, 0, e_fetch(0), 4'd15, 0);
    run_cycle("wrap fetch", OP_BNE, 0, 1, e_fetch(1), 4'd15, 0);
    run_cycle("wrap dec",   OP_BNE, 0, 1, e_dec(),    4'd15, 0);
    run_cycle("wrap br",    OP_BNE, 0, 1, e_br(1),    4'd15, 0);
    run_cycle("wrap zero",  OP_BNE, 0, 0, e_fetch(0), 4'd0,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
